// File: rtl/dijkstra_ram_ctrl_if.sv
// Requester-side access port of the Dijkstra node RAM controller: one request
// slot per cycle, combinational grant, registered read-valid.
interface dijkstra_ram_ctrl_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 14
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              grant;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, input grant, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output grant, rvalid, rdata);
endinterface

// File: rtl/dijkstra_ram_ctrl.sv
// Node RAM front-end: round-robin arbitration of the single RAM slot between
// the bus loader (A) and the Dijkstra engine (B), plus a pre-search init sweep.
module dijkstra_ram_ctrl #(
   parameter int                MAX_NODES  = 15,
   parameter int                ADDR_W     = 9,
   parameter int                DATA_W     = 14,
   parameter logic [DATA_W-1:0] INIT_VALUE = 14'h3FFF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               init_start,
   input  logic [ADDR_W-1:0]  num_nodes,
   output logic               busy,
   output logic               init_done,
   dijkstra_ram_ctrl_if.slave a_port,
   dijkstra_ram_ctrl_if.slave b_port,
   output logic               ram_we,
   output logic [ADDR_W-1:0]  ram_waddr,
   output logic [DATA_W-1:0]  ram_wdata,
   output logic [ADDR_W-1:0]  ram_raddr,
   input  logic [DATA_W-1:0]  ram_rdata
);
   typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, DONE = 2'd2} state_t;

   localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'(MAX_NODES);
   localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] n_q, n_d;
   logic              busy_q, busy_d;
   logic              init_done_q, init_done_d;
   logic              last_b_q, last_b_d;
   logic              a_rvalid_q, a_rvalid_d;
   logic              b_rvalid_q, b_rvalid_d;
   logic              serve;
   logic              a_grant, b_grant;

   // Grants only while IDLE; on a tie the port that did not win last goes first.
   assign serve   = (state_q == IDLE) && reset_n;
   assign a_grant = serve && a_port.req && (!b_port.req || last_b_q);
   assign b_grant = serve && b_port.req && (!a_port.req || !last_b_q);

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = '0;
      ram_wdata = '0;
      ram_raddr = '0;
      if (state_q == INIT) begin
         ram_we    = 1'b1;
         ram_waddr = cnt_q;
         ram_wdata = INIT_VALUE;
      end else if (a_grant) begin
         if (a_port.we) begin
            ram_we    = 1'b1;
            ram_waddr = a_port.addr;
            ram_wdata = a_port.wdata;
         end else begin
            ram_raddr = a_port.addr;
         end
      end else if (b_grant) begin
         if (b_port.we) begin
            ram_we    = 1'b1;
            ram_waddr = b_port.addr;
            ram_wdata = b_port.wdata;
         end else begin
            ram_raddr = b_port.addr;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      busy_d      = 1'b0;
      init_done_d = 1'b0;
      last_b_d    = a_grant ? 1'b0 : (b_grant ? 1'b1 : last_b_q);
      a_rvalid_d  = a_grant && !a_port.we;
      b_rvalid_d  = b_grant && !b_port.we;
      unique case (state_q)
         IDLE: begin
            if (init_start) begin
               cnt_d = '0;
               if (num_nodes == '0) begin
                  state_d     = DONE;
                  init_done_d = 1'b1;
               end else begin
                  n_d     = (num_nodes > MAX_N) ? MAX_N : num_nodes;
                  state_d = INIT;
                  busy_d  = 1'b1;
               end
            end
         end
         INIT: begin
            cnt_d = cnt_q + ONE;
            if (cnt_q == n_q - ONE) begin
               state_d     = DONE;
               init_done_d = 1'b1;
            end else begin
               busy_d = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         n_q         <= '0;
         busy_q      <= 1'b0;
         init_done_q <= 1'b0;
         last_b_q    <= 1'b1;
         a_rvalid_q  <= 1'b0;
         b_rvalid_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         busy_q      <= busy_d;
         init_done_q <= init_done_d;
         last_b_q    <= last_b_d;
         a_rvalid_q  <= a_rvalid_d;
         b_rvalid_q  <= b_rvalid_d;
      end
   end

   assign busy          = busy_q;
   assign init_done     = init_done_q;
   assign a_port.grant  = a_grant;
   assign b_port.grant  = b_grant;
   assign a_port.rvalid = a_rvalid_q;
   assign b_port.rvalid = b_rvalid_q;
   assign a_port.rdata  = ram_rdata;
   assign b_port.rdata  = ram_rdata;
endmodule

// File: tb/tb_dijkstra_ram_ctrl.sv
// Directed bench for dijkstra_ram_ctrl with a behavioural 1-cycle-latency RAM.
module tb_dijkstra_ram_ctrl;
   localparam logic [13:0] INITV = 14'h3FFF;
   localparam logic [13:0] FILL  = 14'h0123;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        init_start = 1'b0;
   logic [8:0]  num_nodes = 9'd0;
   logic        busy, init_done, ram_we;
   logic [8:0]  ram_waddr, ram_raddr;
   logic [13:0] ram_wdata, ram_rdata;
   logic [13:0] mem [0:511];
   int          n_cmp = 0;
   int          n_err = 0;

   dijkstra_ram_ctrl_if #(.ADDR_W(9), .DATA_W(14)) a_if ();
   dijkstra_ram_ctrl_if #(.ADDR_W(9), .DATA_W(14)) b_if ();

   dijkstra_ram_ctrl dut (
      .clk(clk), .reset_n(reset_n), .init_start(init_start), .num_nodes(num_nodes),
      .busy(busy), .init_done(init_done), .a_port(a_if.slave), .b_port(b_if.slave),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      ram_rdata <= mem[ram_raddr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drop_reqs();
      a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
      b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;
   endtask

   task automatic prefill();
      for (int i = 0; i < 15; i++) begin
         a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 9'(i); a_if.wdata = FILL;
         tick();
      end
      drop_reqs();
      tick();
   endtask

   task automatic test_reset();
      drop_reqs();
      reset_n = 1'b0;
      #2;
      n_cmp++;
      if ({busy, init_done, ram_we, a_if.grant, b_if.grant, a_if.rvalid, b_if.rvalid} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_ctrl got=%b exp=0000000",
                  {busy, init_done, ram_we, a_if.grant, b_if.grant, a_if.rvalid, b_if.rvalid});
      end
      n_cmp++;
      if ({ram_waddr, ram_raddr, ram_wdata} !== 32'd0) begin
         n_err++;
         $display("FAIL reset_bus got=%h exp=0", {ram_waddr, ram_raddr, ram_wdata});
      end
      tick();
      reset_n = 1'b1;
      tick();
      a_if.req = 1'b1; a_if.addr = 9'd0;
      b_if.req = 1'b1; b_if.addr = 9'd1;
      @(negedge clk);
      n_cmp++;
      if ({a_if.grant, b_if.grant} !== 2'b10) begin
         n_err++;
         $display("FAIL first_tie got=%b exp=10", {a_if.grant, b_if.grant});
      end
      tick();
      drop_reqs();
      tick();
   endtask

   task automatic test_sweep();
      logic [25:0] exp_v;
      init_start = 1'b1; num_nodes = 9'd5;
      @(negedge clk);
      n_cmp++;
      if ({busy, init_done} !== 2'b00) begin
         n_err++;
         $display("FAIL sweep_c0 got=%b exp=00", {busy, init_done});
      end
      tick();
      init_start = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         exp_v = {c <= 5, c == 6, c <= 5, (c <= 5) ? 9'(c - 1) : 9'd0, (c <= 5) ? INITV : 14'd0};
         n_cmp++;
         if ({busy, init_done, ram_we, ram_waddr, ram_wdata} !== exp_v) begin
            n_err++;
            $display("FAIL sweep_c%0d got=%h exp=%h", c,
                     {busy, init_done, ram_we, ram_waddr, ram_wdata}, exp_v);
         end
         tick();
      end
      for (int i = 0; i < 15; i++) begin
         n_cmp++;
         if (mem[i] !== ((i < 5) ? INITV : FILL)) begin
            n_err++;
            $display("FAIL sweep_mem%0d got=%h exp=%h", i, mem[i], (i < 5) ? INITV : FILL);
         end
      end
   endtask

   task automatic test_clamp_zero();
      logic [11:0] exp_v;
      int          writes;
      writes = 0;
      init_start = 1'b1; num_nodes = 9'd20;
      tick();
      init_start = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         @(negedge clk);
         if (ram_we) writes++;
         exp_v = {c <= 15, c == 16, c <= 15, (c <= 15) ? 9'(c - 1) : 9'd0};
         n_cmp++;
         if ({busy, init_done, ram_we, ram_waddr} !== exp_v) begin
            n_err++;
            $display("FAIL clamp_c%0d got=%h exp=%h", c, {busy, init_done, ram_we, ram_waddr}, exp_v);
         end
         tick();
      end
      n_cmp++;
      if (writes != 15) begin
         n_err++;
         $display("FAIL clamp_writes got=%0d exp=15", writes);
      end
      init_start = 1'b1; num_nodes = 9'd0;
      for (int c = 0; c <= 2; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({busy, init_done, ram_we} !== {1'b0, c == 1, 1'b0}) begin
            n_err++;
            $display("FAIL zero_c%0d got=%b exp=%b", c, {busy, init_done, ram_we}, {1'b0, c == 1, 1'b0});
         end
         tick();
         init_start = 1'b0;
      end
   endtask

   task automatic test_read_latency();
      a_if.req = 1'b1; a_if.we = 1'b1; a_if.addr = 9'd7; a_if.wdata = 14'h1A5;
      @(negedge clk);
      n_cmp++;
      if ({a_if.grant, ram_we, ram_waddr, ram_wdata} !== {1'b1, 1'b1, 9'd7, 14'h1A5}) begin
         n_err++;
         $display("FAIL rl_write got=%h exp=%h", {a_if.grant, ram_we, ram_waddr, ram_wdata},
                  {1'b1, 1'b1, 9'd7, 14'h1A5});
      end
      tick();
      a_if.we = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({a_if.grant, ram_we, ram_raddr, a_if.rvalid} !== {1'b1, 1'b0, 9'd7, 1'b0}) begin
         n_err++;
         $display("FAIL rl_read got=%h exp=%h", {a_if.grant, ram_we, ram_raddr, a_if.rvalid},
                  {1'b1, 1'b0, 9'd7, 1'b0});
      end
      tick();
      drop_reqs();
      @(negedge clk);
      n_cmp++;
      if ({a_if.rvalid, b_if.rvalid, a_if.rdata} !== {1'b1, 1'b0, 14'h1A5}) begin
         n_err++;
         $display("FAIL rl_data got=%h exp=%h", {a_if.rvalid, b_if.rvalid, a_if.rdata},
                  {1'b1, 1'b0, 14'h1A5});
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (a_if.rvalid !== 1'b0) begin
         n_err++;
         $display("FAIL rl_pulse got=%b exp=0", a_if.rvalid);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 9'd3; b_if.wdata = 14'h2B6;
      @(negedge clk);
      n_cmp++;
      if ({a_if.grant, b_if.grant, ram_we, ram_waddr} !== {1'b0, 1'b1, 1'b1, 9'd3}) begin
         n_err++;
         $display("FAIL b2b_bwrite got=%h exp=%h", {a_if.grant, b_if.grant, ram_we, ram_waddr},
                  {1'b0, 1'b1, 1'b1, 9'd3});
      end
      tick();
      drop_reqs();
      a_if.req = 1'b1; a_if.addr = 9'd7;
      tick();
      a_if.addr = 9'd3;
      @(negedge clk);
      n_cmp++;
      if ({a_if.rvalid, a_if.rdata} !== {1'b1, 14'h1A5}) begin
         n_err++;
         $display("FAIL b2b_first got=%h exp=%h", {a_if.rvalid, a_if.rdata}, {1'b1, 14'h1A5});
      end
      tick();
      drop_reqs();
      @(negedge clk);
      n_cmp++;
      if ({a_if.rvalid, a_if.rdata} !== {1'b1, 14'h2B6}) begin
         n_err++;
         $display("FAIL b2b_second got=%h exp=%h", {a_if.rvalid, a_if.rdata}, {1'b1, 14'h2B6});
      end
      tick();
   endtask

   task automatic test_contention();
      logic prev_a, prev_b, ea, eb;
      // The previous scenario ended on an A access; one B write makes A the next tie winner.
      b_if.req = 1'b1; b_if.we = 1'b1; b_if.addr = 9'd3; b_if.wdata = 14'h2B6;
      tick();
      prev_a = 1'b0; prev_b = 1'b0;
      a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 9'd7;
      b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 9'd3;
      for (int c = 0; c <= 7; c++) begin
         if (c == 6) drop_reqs();
         ea = (c < 6) && (c % 2 == 0);
         eb = (c < 6) && (c % 2 == 1);
         @(negedge clk);
         n_cmp++;
         if ({a_if.grant, b_if.grant, a_if.rvalid, b_if.rvalid} !== {ea, eb, prev_a, prev_b}) begin
            n_err++;
            $display("FAIL cont_c%0d got=%b exp=%b", c, {a_if.grant, b_if.grant, a_if.rvalid, b_if.rvalid},
                     {ea, eb, prev_a, prev_b});
         end
         if (prev_a || prev_b) begin
            n_cmp++;
            if (ram_rdata !== (prev_a ? 14'h1A5 : 14'h2B6)) begin
               n_err++;
               $display("FAIL cont_data_c%0d got=%h exp=%h", c, ram_rdata, prev_a ? 14'h1A5 : 14'h2B6);
            end
         end
         prev_a = ea; prev_b = eb;
         tick();
      end
   endtask

   task automatic test_stall_sweep();
      int  grants, valids;
      logic drop;
      grants = 0; valids = 0; drop = 1'b0;
      init_start = 1'b1; num_nodes = 9'd5;
      tick();
      for (int c = 1; c <= 9; c++) begin
         init_start = (c == 3);
         num_nodes  = (c == 3) ? 9'd2 : 9'd5;
         if (c == 2) begin b_if.req = 1'b1; b_if.we = 1'b0; b_if.addr = 9'd7; end
         if (drop) begin b_if.req = 1'b0; drop = 1'b0; end
         @(negedge clk);
         if (b_if.grant) begin grants++; drop = 1'b1; end
         if (b_if.rvalid) valids++;
         n_cmp++;
         if ({busy, init_done, b_if.grant, b_if.rvalid} !== {c <= 5, c == 6, c == 7, c == 8}) begin
            n_err++;
            $display("FAIL stall_c%0d got=%b exp=%b", c, {busy, init_done, b_if.grant, b_if.rvalid},
                     {c <= 5, c == 6, c == 7, c == 8});
         end
         if (c == 7) begin
            n_cmp++;
            if (ram_raddr !== 9'd7) begin
               n_err++;
               $display("FAIL stall_raddr got=%0d exp=7", ram_raddr);
            end
         end
         if (c == 8) begin
            n_cmp++;
            if (b_if.rdata !== 14'h1A5) begin
               n_err++;
               $display("FAIL stall_rdata got=%h exp=1a5", b_if.rdata);
            end
         end
         tick();
      end
      init_start = 1'b0;
      drop_reqs();
      n_cmp++;
      if ({grants, valids} !== {32'd1, 32'd1}) begin
         n_err++;
         $display("FAIL stall_counts got=%0d/%0d exp=1/1", grants, valids);
      end
   endtask

   task automatic test_reset_mid_sweep();
      logic [11:0] exp_v;
      prefill();
      init_start = 1'b1; num_nodes = 9'd10;
      tick();
      init_start = 1'b0;
      tick();
      tick();
      a_if.req = 1'b1; a_if.we = 1'b0; a_if.addr = 9'd4;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, init_done, ram_we, a_if.grant, a_if.rvalid, b_if.rvalid} !== 6'b0) begin
         n_err++;
         $display("FAIL midrst_out got=%b exp=000000",
                  {busy, init_done, ram_we, a_if.grant, a_if.rvalid, b_if.rvalid});
      end
      drop_reqs();
      tick();
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         n_cmp++;
         if ({busy, init_done, ram_we} !== 3'b000) begin
            n_err++;
            $display("FAIL midrst_idle_c%0d got=%b exp=000", c, {busy, init_done, ram_we});
         end
         tick();
      end
      for (int i = 0; i < 15; i++) begin
         n_cmp++;
         if (mem[i] !== ((i < 2) ? INITV : FILL)) begin
            n_err++;
            $display("FAIL midrst_mem%0d got=%h exp=%h", i, mem[i], (i < 2) ? INITV : FILL);
         end
      end
      init_start = 1'b1; num_nodes = 9'd3;
      tick();
      init_start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         exp_v = {c <= 3, c == 4, c <= 3, (c <= 3) ? 9'(c - 1) : 9'd0};
         n_cmp++;
         if ({busy, init_done, ram_we, ram_waddr} !== exp_v) begin
            n_err++;
            $display("FAIL restart_c%0d got=%h exp=%h", c, {busy, init_done, ram_we, ram_waddr}, exp_v);
         end
         tick();
      end
   endtask

   initial begin
      drop_reqs();
      test_reset();
      prefill();
      test_sweep();
      test_clamp_zero();
      test_read_latency();
      test_back_to_back();
      test_contention();
      test_stall_sweep();
      test_reset_mid_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dijkstra_ram_ctrl.md
# dijkstra_ram_ctrl

Controller that sits in front of the pathfinding node RAM, a 1-read/1-write M10K with registered read and 1-cycle latency. It multiplexes the RAM's single access slot between two requesters: port A is the HPS/bus loader used to write the graph and read results back; port B is the Dijkstra engine. It also runs a hardware sweep that initialises node entries 0..n-1 to a fixed value before each search. One RAM access per cycle; the arbiter is round-robin.

## Interface
- MAX_NODES, 15, number of RAM entries.
- ADDR_W, 9, address width.
- DATA_W, 14, node entry width.
- INIT_VALUE, 14'h3FFF, value written by the init sweep ("infinite distance, unvisited").
- clk  in  1  single clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init_start  in  1  one-cycle pulse that starts the sweep.
- num_nodes  in  ADDR_W  entry count to sweep; latched when init_start is accepted.
- busy  out  1  high while the sweep runs.
- init_done  out  1  one-cycle pulse when the sweep completes.
- a_req / b_req  in  1  access request; held until granted.
- a_we / b_we  in  1  1 = write, 0 = read; stable while req is high.
- a_addr / b_addr  in  ADDR_W  address; stable while req is high.
- a_wdata / b_wdata  in  DATA_W  write data.
- a_grant / b_grant  out  1  combinational; the access is issued to the RAM this cycle.
- a_rvalid / b_rvalid  out  1  registered; read data is valid this cycle.
- a_rdata / b_rdata  out  DATA_W  both driven from ram_rdata; meaningful only when the matching rvalid is high.
- ram_we  out  1, ram_waddr  out  ADDR_W, ram_wdata  out  DATA_W, ram_raddr  out  ADDR_W  RAM control.
- ram_rdata  in  DATA_W  RAM registered read output.

## Operation
- States:
  - IDLE serves requesters.
  - INIT runs the sweep.
  - DONE lasts one cycle and asserts init_done.
- IDLE → INIT: on init_start.
  - Latch n = min(num_nodes, MAX_NODES).
  - Clear the write counter.
- IDLE → DONE: on init_start with num_nodes = 0. No writes occur.
- INIT:
  - Each cycle drive ram_we = 1, ram_waddr = counter, ram_wdata = INIT_VALUE, then increment the counter.
  - After the write to address n-1, go to DONE.
- DONE → IDLE unconditionally.
- init_start while in INIT or DONE is ignored.
- No grants are issued in INIT or DONE. Pending requests stay pending.
- Arbitration in IDLE:
  - Only one requester active: grant it.
  - Both active: grant the port not granted most recently.
  - The last_grant flag resets to B, so A wins the first tie.
- Granted write: ram_we = 1, ram_waddr / ram_wdata taken from the port.
- Granted read: ram_raddr = port address. The port's rvalid goes high on the next cycle.
- When no read is issued, ram_raddr = 0. When no write is issued, ram_we = 0, ram_waddr = 0, ram_wdata = 0.
- A read and a write never coincide because there is one slot per cycle, so no read-during-write hazard exists.
  - A write granted in cycle N followed by a read of the same address in cycle N+1 returns the new data.
- Reset (asynchronous, any state):
  - state = IDLE; busy, init_done, grants, rvalids, ram_we = 0; counter = 0; last_grant = B.
  - RAM contents are not touched. A sweep interrupted by reset is abandoned and is not resumed.

## Timing
- Sweep, with init_start accepted at edge of cycle 0:
  - busy is high in cycles 1..n.
  - Address k is written in cycle k+1.
  - init_done is high in cycle n+1, with busy low.
  - The first grant is possible in cycle n+2.
- num_nodes = 0: init_done in cycle 1; busy never rises.
- Read latency:
  - grant in cycle N → rvalid and valid rdata in cycle N+1, for one cycle.
  - Back-to-back reads sustain one per cycle.
- Grant is combinational from req, state and last_grant. last_grant updates at the edge closing the granted cycle.
- Throughput with both ports continuously requesting: strict alternation A, B, A, B …

## Test plan
- Sweep: RAM pre-filled with 14'h0123, init_start with num_nodes = 5 → INIT_VALUE written to addresses 0..4 in cycles 1..5; addresses 5..14 still read 14'h0123; init_done only in cycle 6.
- Clamp and zero: num_nodes = 20 → exactly 15 writes (0..14), init_done in cycle 16. num_nodes = 0 → no ram_we, init_done in cycle 1.
- Read latency: A writes 14'h1A5 to address 7; next cycle A reads 7 → a_rvalid one cycle later with a_rdata = 14'h1A5; b_rvalid stays 0.
- Contention: A and B both request reads continuously for 6 cycles → grants A, B, A, B, A, B; each rvalid pulses exactly one cycle after its grant.
- Stall during sweep: b_req asserted in cycle 2 of a 5-node sweep → no b_grant until cycle 7; request honoured then, with no lost or duplicated access.
- Reset mid-sweep: reset_n low in cycle 3 of a 10-node sweep → all outputs 0 immediately; addresses 0..1 hold INIT_VALUE, address 2 onward unchanged; no init_done; next init_start restarts from address 0.
